// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end and its RAM.
package spi_pkg;

  // Slave FSM states
  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Width of the command field at the head of every frame
  localparam int CMD_W = 2;

  // Command field decode
  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// Single-port RAM driven by complete SPI frames {cmd, payload}.
// The write/read address registers live here; contents survive reset.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] din_i,
  input  logic                 rx_valid_i,
  output logic [ADDR_SIZE-1:0] dout_o,
  output logic                 tx_valid_o
);

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  logic [CMD_W-1:0]     cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;

  assign cmd     = din_i[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = din_i[ADDR_SIZE-1:0];

  // Decode a finished frame into address updates or a read
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    if (rx_valid_i) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload;
        CMD_RD_ADDR: rd_addr_d = payload;
        CMD_RD_DATA: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage array: no reset, writes blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && rx_valid_i && cmd == CMD_WR_DATA) mem[wr_addr_q] <= payload;
  end

  assign dout_o     = dout_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave (clocked by the system clock) in front of an on-chip RAM.
// A frame is: SS_n low, one path bit, then {cmd[1:0], payload} MSB first.
// Read data is shifted out on MISO starting two edges after the last bit.
module spi_wrapper
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,   // active-high synchronous reset despite the name
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  localparam int FRAME_BITS = ADDR_SIZE + CMD_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int TXC_W      = $clog2(ADDR_SIZE);

  state_e               state_q, state_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 miso_q, miso_d;
  logic                 rd_addr_done_q, rd_addr_done_d;

  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk        (clk),
    .rst        (rst_n),
    .din_i      (rx_data_q),
    .rx_valid_i (rx_valid_q),
    .dout_o     (ram_dout),
    .tx_valid_o (ram_tx_valid)
  );

  // Next state: SS_n high always drops back to IDLE
  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Receive shifter, frame strobe, MISO shifter and read-address flag
  always_comb begin
    rx_data_d      = rx_data_q;
    rx_cnt_d       = rx_cnt_q;
    rx_valid_d     = 1'b0;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    miso_d         = miso_q;
    rd_addr_done_d = rd_addr_done_q;

    // The RAM latches the read address on the same edge this flag sets
    if (rx_valid_q && rx_data_q[FRAME_BITS-1 -: CMD_W] == CMD_RD_ADDR)
      rd_addr_done_d = 1'b1;

    if (SS_n) begin
      rx_cnt_d  = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, CHK_CMD: rx_cnt_d = '0;
        default: begin
          // Bits past the end of the frame are ignored
          if (rx_cnt_q != CNT_W'(FRAME_BITS)) begin
            rx_data_d  = {rx_data_q[FRAME_BITS-2:0], MOSI};
            rx_cnt_d   = rx_cnt_q + 1'b1;
            rx_valid_d = (rx_cnt_q == CNT_W'(FRAME_BITS - 1));
          end
          if (state_q == READ_DATA) begin
            if (ram_tx_valid && !tx_busy_q) begin
              tx_busy_d  = 1'b1;
              miso_d     = ram_dout[ADDR_SIZE-1];
              tx_shift_d = {ram_dout[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d   = TXC_W'(ADDR_SIZE - 1);
            end else if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - 1'b1;
              end else begin
                // Last bit has been held for a full cycle: read complete
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                rd_addr_done_d = 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= IDLE;
      rx_data_q      <= '0;
      rx_cnt_q       <= '0;
      rx_valid_q     <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_data_q      <= rx_data_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_valid_q     <= rx_valid_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      miso_q         <= miso_d;
      rd_addr_done_q <= rd_addr_done_d;
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_wrapper.sv
// Bench for spi_wrapper: frames are driven edge by edge; a transaction-level
// model (address registers, read flag, memory array) predicts MISO after
// every clock edge, plus a few literal checks of key internal state.
module tb_spi_wrapper;
  import spi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic MOSI  = 1'b0;
  logic SS_n  = 1'b1;
  logic MISO;

  always #5 clk = ~clk;

  spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MOSI  (MOSI),
    .SS_n  (SS_n),
    .MISO  (MISO)
  );

  int checks = 0;
  int errors = 0;

  logic       exp_miso = 1'b0;
  logic [7:0] m_mem [256];
  logic [7:0] m_wr   = 8'h00;
  logic [7:0] m_rd   = 8'h00;
  bit         m_done = 1'b0;
  logic [7:0] cap;

  // One clock edge, then compare MISO with the model's prediction
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (MISO !== exp_miso) begin
      errors++;
      $display("FAIL miso t=%0t got %b exp %b", $time, MISO, exp_miso);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // Edge 0: SS_n low seen in IDLE; edge 1: path bit; edges 2..11: frame bits.
  // A read-data frame in the read path returns byte bit 7 after edge 13
  // down to bit 0 after edge 20. nbits < 10 aborts the frame early.
  task automatic frame(input bit path, input logic [1:0] cmd, input logic [7:0] pay,
                       input int nbits, input int extra, input int rst_edge);
    logic [9:0] f;
    logic [7:0] b;
    bit         outp;
    bit         rst_hit;
    int         total;
    f       = {cmd, pay};
    b       = m_mem[m_rd];
    outp    = path && m_done && cmd == 2'b11 && nbits == 10;
    rst_hit = 1'b0;
    cap     = 8'h00;
    total   = 2 + nbits + ((nbits == 10) ? extra : 0);
    for (int e = 0; e < total; e++) begin
      SS_n = 1'b0;
      if (e == 1)                  MOSI = path;
      else if (e >= 2 && e - 2 < nbits) MOSI = f[9 - (e - 2)];
      else                         MOSI = 1'($urandom_range(0, 1));
      exp_miso = (outp && e >= 13 && e <= 20) ? b[20 - e] : 1'b0;
      if (e == rst_edge) begin
        rst_n    = 1'b1;
        exp_miso = 1'b0;
        rst_hit  = 1'b1;
      end
      tick();
      if (outp && e >= 13 && e <= 20) cap = {cap[6:0], MISO};
      if (rst_hit) break;
    end
    SS_n     = 1'b1;
    rst_n    = 1'b0;
    exp_miso = 1'b0;
    tick();
    if (nbits == 10) begin
      case (cmd)
        2'b00: m_wr = pay;
        2'b01: m_mem[m_wr] = pay;
        2'b10: begin m_rd = pay; m_done = 1'b1; end
        default: ;
      endcase
      if (outp) m_done = 1'b0;
    end
    if (rst_hit) begin
      m_wr   = 8'h00;
      m_rd   = 8'h00;
      m_done = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_done", 32'(dut.rd_addr_done_q), 32'd0);
    chk("rst_wr_addr", 32'(dut.u_ram.wr_addr_q), 32'd0);
    chk("rst_rd_addr", 32'(dut.u_ram.rd_addr_q), 32'd0);

    // Directed transactions
    frame(1'b0, 2'b00, 8'h0A, 10, 0, -1);
    chk("wr_addr", 32'(dut.u_ram.wr_addr_q), 32'h0A);
    frame(1'b0, 2'b01, 8'h55, 10, 0, -1);
    chk("mem_0a", 32'(dut.u_ram.mem[8'h0A]), 32'h55);
    frame(1'b1, 2'b10, 8'h0A, 10, 0, -1);
    chk("rd_addr", 32'(dut.u_ram.rd_addr_q), 32'h0A);
    chk("done_set", 32'(dut.rd_addr_done_q), 32'd1);
    frame(1'b1, 2'b11, 8'h00, 10, 10, -1);
    chk("read_bits", 32'(cap), 32'h55);
    chk("done_clr", 32'(dut.rd_addr_done_q), 32'd0);

    // Abort after 5 payload bits of a write-data frame
    frame(1'b0, 2'b01, 8'hAA, 7, 0, -1);
    chk("abort_mem", 32'(dut.u_ram.mem[8'h0A]), 32'h55);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));

    // Reset in the middle of the read-data shift
    frame(1'b1, 2'b10, 8'h0A, 10, 0, -1);
    frame(1'b1, 2'b11, 8'h00, 10, 10, 14);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mrst_mem", 32'(dut.u_ram.mem[8'h0A]), 32'h55);
    chk("mrst_done", 32'(dut.rd_addr_done_q), 32'd0);

    // Fill every location so later reads are defined
    for (int a = 0; a < 256; a++) begin
      frame(1'b0, 2'b00, 8'(a), 10, 0, -1);
      frame(1'b0, 2'b01, 8'($urandom_range(0, 255)), 10, 0, -1);
    end

    // Guaranteed read-backs at random addresses
    for (int i = 0; i < 8; i++) begin
      frame(1'b1, 2'b10, 8'($urandom_range(0, 255)), 10, $urandom_range(0, 3), -1);
      frame(1'b1, 2'b11, 8'($urandom_range(0, 255)), 10, 10 + $urandom_range(0, 2), -1);
    end

    // Random mix including mismatched path bits, aborts and trailing bits
    for (int i = 0; i < 250; i++) begin
      logic [1:0] cmd;
      bit         path;
      int         nb;
      int         ex;
      cmd  = 2'($urandom_range(0, 3));
      path = cmd[1];
      if ($urandom_range(0, 7) == 0) path = ~path;
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
      ex = (path && m_done && cmd == 2'b11) ? 10 + $urandom_range(0, 2)
                                            : $urandom_range(0, 3);
      frame(path, cmd, 8'($urandom_range(0, 255)), nb, ex, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
